// File: rtl/present_pkg.sv
// PRESENT key schedule shared types, S-box and round-key update functions.
// Optional zeroize state is enabled by PRESENT_KEY_ZEROIZE_EN.
package present_pkg;

  localparam int KEY_SIZE_DEF   = 80;
  localparam int NUM_ROUNDS_DEF = 31;
  localparam int RK_W           = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
`ifdef PRESENT_KEY_ZEROIZE_EN
    ST_READY,
    ST_ZERO
`else
    ST_READY
`endif
  } state_t;

  // Nibble i of the table is S(i).
  localparam logic [63:0] SBOX_TBL = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [79:0] update80(
    input logic [79:0] k,
    input logic [4:0]  c
  );
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ c;
    return r;
  endfunction

  function automatic logic [127:0] update128(
    input logic [127:0] k,
    input logic [4:0]   c
  );
    logic [127:0] r;
    r          = {k[66:0], k[127:67]};
    r[127:124] = sbox(r[127:124]);
    r[123:120] = sbox(r[123:120]);
    r[66:62]   = r[66:62] ^ c;
    return r;
  endfunction

endpackage

// File: rtl/present_key_round.sv
// Combinational single-round PRESENT key update: (key, cnt) -> next key.
// Variant selected by KEY_SIZE (80 or 128).
module present_key_round
  import present_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_DEF
) (
  input  logic [KEY_SIZE-1:0] key,
  input  logic [4:0]          cnt,
  output logic [KEY_SIZE-1:0] nk
);

  if (KEY_SIZE == 128) begin : g_k128
    assign nk = update128(key, cnt);
  end else begin : g_k80
    assign nk = update80(key, cnt);
  end

endmodule

// File: rtl/present_key_sched_ctrl.sv
// Sequential PRESENT key schedule with 32-entry round-key store and read port.
// PRESENT_KEY_ZEROIZE_EN adds a ZERO state that wipes storage on abort.
module present_key_sched_ctrl
  import present_pkg::*;
#(
  parameter int KEY_SIZE   = KEY_SIZE_DEF,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [KEY_SIZE-1:0] key_in,
  output logic                busy,
  output logic                ready,
  input  logic                rd_en,
  input  logic [4:0]          rd_idx,
  output logic [RK_W-1:0]     rd_key,
  output logic                rd_valid
);

  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

  state_t              state;
  logic [KEY_SIZE-1:0] key_reg;
  logic [KEY_SIZE-1:0] nk;
  logic [4:0]          cnt;
  logic [RK_W-1:0]     rk [NUM_ROUNDS+1];

  present_key_round #(
    .KEY_SIZE(KEY_SIZE)
  ) u_round (
    .key(key_reg),
    .cnt(cnt),
    .nk (nk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
      rd_key   <= '0;
      cnt      <= '0;
      key_reg  <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      // Read port sees pre-edge ready and storage.
      rd_valid <= rd_en && ready;
      if (rd_en && ready) rd_key <= rk[rd_idx];

      unique case (state)
        ST_IDLE, ST_READY: begin
          if (abort) begin
`ifdef PRESENT_KEY_ZEROIZE_EN
            if (state == ST_READY) begin
              state   <= ST_ZERO;
              busy    <= 1'b1;
              key_reg <= '0;
              cnt     <= '0;
            end
`else
            state <= ST_IDLE;
            busy  <= 1'b0;
`endif
            ready <= 1'b0;
          end else if (start) begin
            key_reg <= key_in;
            rk[0]   <= key_in[KEY_SIZE-1 -: RK_W];
            cnt     <= 5'd1;
            state   <= ST_EXPAND;
            busy    <= 1'b1;
            ready   <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (abort) begin
`ifdef PRESENT_KEY_ZEROIZE_EN
            state   <= ST_ZERO;
            busy    <= 1'b1;
            key_reg <= '0;
            cnt     <= '0;
`else
            state <= ST_IDLE;
            busy  <= 1'b0;
`endif
            ready <= 1'b0;
          end else begin
            key_reg <= nk;
            rk[cnt] <= nk[KEY_SIZE-1 -: RK_W];
            cnt     <= cnt + 5'd1;
            if (cnt == LAST) begin
              state <= ST_READY;
              busy  <= 1'b0;
              ready <= 1'b1;
              cnt   <= '0;
            end
          end
        end
`ifdef PRESENT_KEY_ZEROIZE_EN
        ST_ZERO: begin
          rk[cnt] <= '0;
          cnt     <= cnt + 5'd1;
          if (cnt == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// Directed bench for present_key_sched_ctrl (80-bit default build).
// Extra zeroize checks run when PRESENT_KEY_ZEROIZE_EN is defined.
module tb_present_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [79:0] key_in = '0;
  logic        busy, ready;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_idx = '0;
  logic [63:0] rd_key;
  logic        rd_valid;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  present_key_sched_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .key_in  (key_in),
    .busy    (busy),
    .ready   (ready),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_key  (rd_key),
    .rd_valid(rd_valid)
  );

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [79:0] upd(
    input logic [79:0] k,
    input logic [4:0]  c
  );
    logic [159:0] d;
    logic [79:0]  r;
    d        = {k, k};
    r        = d[98:19];
    r[79:76] = SB[r[79:76]];
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] exp;
  } vec_t;

  logic [63:0] gold [32];

  task automatic gen_gold(input logic [79:0] k);
    logic [79:0] kk;
    kk = k;
    gold[0] = kk[79:16];
    for (int i = 1; i < 32; i++) begin
      kk = upd(kk, 5'(i));
      gold[i] = kk[79:16];
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [79:0] k);
    key_in = k;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Counts edges until ready, starting from n0; also flags busy drops.
  task automatic wait_ready(input int n0, output int n, output int bad);
    n   = n0;
    bad = 0;
    while (!ready && n < 100) begin
      if (!busy) bad++;
      step();
      n++;
    end
  endtask

  task automatic rd(input logic [4:0] i);
    rd_en  = 1'b1;
    rd_idx = i;
    step();
    rd_en  = 1'b0;
  endtask

  vec_t tbl [3];
  int   n, bad;

  initial begin
    tbl[0] = '{5'd0,  64'h0000000000000000};
    tbl[1] = '{5'd1,  64'hC000000000000000};
    tbl[2] = '{5'd31, 64'h6DAB31744F41D700};

    #3;
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_ready",    64'(ready),    64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_key",   rd_key,        64'd0);
    step();
    rst_n = 1'b1;
    step();

    pulse_start(80'h0);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_ready(0, n, bad);
    chk("latency_k0",  64'(n),   64'd31);
    chk("busy_during", 64'(bad), 64'd0);
    chk("busy_done",   64'(busy), 64'd0);

    for (int t = 0; t < 3; t++) begin
      rd(tbl[t].idx);
      chk("tbl_rd_valid", 64'(rd_valid), 64'd1);
      chk($sformatf("tbl_rk%0d", tbl[t].idx), rd_key, tbl[t].exp);
    end
    step();
    chk("rd_valid_idle", 64'(rd_valid), 64'd0);

    // Restart from READY with a concurrent read of the old contents.
    gen_gold({80{1'b1}});
    key_in = {80{1'b1}};
    start  = 1'b1;
    rd_en  = 1'b1;
    rd_idx = 5'd1;
    step();
    start  = 1'b0;
    rd_en  = 1'b0;
    chk("restart_rd_valid", 64'(rd_valid), 64'd1);
    chk("restart_rd_key",   rd_key, 64'hC000000000000000);
    chk("restart_ready",    64'(ready), 64'd0);
    chk("restart_busy",     64'(busy),  64'd1);
    wait_ready(0, n, bad);
    chk("latency_ff", 64'(n), 64'd31);

    for (int i = 0; i < 32; i++) begin
      rd_en  = 1'b1;
      rd_idx = 5'(i);
      step();
      chk("b2b_valid", 64'(rd_valid), 64'd1);
      chk($sformatf("b2b_rk%0d", i), rd_key, gold[i]);
    end
    rd_en = 1'b0;
    step();
    chk("b2b_valid_drop", 64'(rd_valid), 64'd0);

    // start mid-expansion is ignored.
    pulse_start(80'h0);
    for (int i = 0; i < 9; i++) step();
    key_in = {80{1'b1}};
    start  = 1'b1;
    step();
    start  = 1'b0;
    wait_ready(10, n, bad);
    chk("latency_ignored_start", 64'(n), 64'd31);
    rd(5'd31);
    chk("ignored_start_rk31", rd_key, 64'h6DAB31744F41D700);

    // abort mid-expansion.
    pulse_start(80'h0);
    for (int i = 0; i < 9; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ready", 64'(ready), 64'd0);
`ifdef PRESENT_KEY_ZEROIZE_EN
    chk("abort_busy", 64'(busy), 64'd1);
`else
    chk("abort_busy", 64'(busy), 64'd0);
`endif
    rd(5'd3);
    chk("abort_rd_valid", 64'(rd_valid), 64'd0);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("abort_settle", 64'(busy), 64'd0);

    // start and abort together in READY: no restart.
    pulse_start(80'h0);
    wait_ready(0, n, bad);
    chk("latency_pre_sa", 64'(n), 64'd31);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_ready", 64'(ready), 64'd0);
`ifdef PRESENT_KEY_ZEROIZE_EN
    chk("sa_busy", 64'(busy), 64'd1);
`else
    chk("sa_busy", 64'(busy), 64'd0);
`endif
    for (int i = 0; i < 40; i++) step();
    chk("sa_busy_late",  64'(busy),  64'd0);
    chk("sa_ready_late", 64'(ready), 64'd0);

    // Reset mid-expansion; rd_key is nonzero from the earlier read.
    pulse_start(80'h0);
    wait_ready(0, n, bad);
    rd(5'd31);
    pulse_start(80'h0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",     64'(busy),     64'd0);
    chk("mid_rst_ready",    64'(ready),    64'd0);
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_rd_key",   rd_key,        64'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef PRESENT_KEY_ZEROIZE_EN
    pulse_start({80{1'b1}});
    wait_ready(0, n, bad);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk("zero_busy_cycles", 64'(n), 64'd32);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.rk[i] != 64'd0) bad++;
    chk("zero_storage", 64'(bad), 64'd0);
    pulse_start(80'h0);
    wait_ready(0, n, bad);
    chk("zero_restart_latency", 64'(n), 64'd31);
    rd(5'd31);
    chk("zero_restart_rk31", rd_key, 64'h6DAB31744F41D700);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/present_key_sched_ctrl.md
Name: present_key_sched_ctrl

Overview:
- Sequential controller for the PRESENT key schedule.
- On `start`, latches the user key and iterates one schedule round per clock, computing K1..K32.
- Stores all 32 round keys in an internal 32x64 register file.
- Serves them to the cipher datapath through a registered read port.
- Replaces the combinational all-rounds key path; the cipher core reads its round keys only from this block.

Parameters:
- KEY_SIZE, 80, user key width; 80 or 128 only; selects the update function.
- NUM_ROUNDS, 31, cipher rounds; storage depth is NUM_ROUNDS+1.
- RK_W, 64, round key width; always bits [KEY_SIZE-1:KEY_SIZE-64] of the key register.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin expansion of key_in.
- abort  in  1  pulse; cancel expansion or invalidate stored keys.
- key_in  in  KEY_SIZE  user key, sampled only on the accepted start edge.
- busy  out  1  expansion (or zeroize) in progress.
- ready  out  1  all round keys valid.
- rd_en  in  1  read request.
- rd_idx  in  5  round key index; 0 returns K1, 31 returns K32.
- rd_key  out  RK_W  registered round key.
- rd_valid  out  1  rd_key valid this cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, ready=0, rd_valid=0, rd_key=0, cnt=0, key_reg=0, all storage=0.
- States: IDLE, EXPAND, READY, plus ZERO when the optional feature is compiled in.
- IDLE/READY with start=1, abort=0, at edge E0:
  - key_reg<=key_in; rk[0]<=key_in[KEY_SIZE-1 -: 64]; cnt<=1.
  - state->EXPAND, busy<=1, ready<=0.
- EXPAND, each edge:
  - nk=update(key_reg,cnt); key_reg<=nk; rk[cnt]<=nk[top 64]; cnt<=cnt+1.
  - On the edge where cnt==31: state->READY, busy<=0, ready<=1.
  - Latency: ready rises at edge E0+31.
- update, 80-bit:
  - rotate left 61;
  - S-box on bits [79:76];
  - bits [19:15] ^= cnt.
- update, 128-bit:
  - rotate left 61;
  - S-box on bits [127:124] and [123:120];
  - bits [66:62] ^= cnt.
- cnt is 5 bits and never wraps within an expansion (1..31).
- start during EXPAND: ignored.
- start in READY: restarts expansion; ready drops at the same edge.
- abort has priority over start in every state:
  - EXPAND->IDLE; READY->IDLE; busy<=0, ready<=0.
  - Storage is left unchanged unless the feature is enabled.
- Reads:
  - rd_en=1 and ready=1 at an edge: rd_key<=rk[rd_idx], rd_valid<=1 (1-cycle latency).
  - Otherwise rd_valid<=0 and rd_key holds its value.
  - Reads are back-to-back capable (one per cycle).
- rd_en together with start in READY: the read is served from pre-edge contents with rd_valid=1.
- Reset asserted mid-expansion: immediate return to reset values.

Optional Feature:
- Macro PRESENT_KEY_ZEROIZE_EN.
- Defined:
  - abort from EXPAND or READY enters ZERO (busy=1, ready=0).
  - ZERO clears key_reg at entry, then one rk entry per cycle for 32 cycles, then goes to IDLE.
  - start is ignored while in ZERO.
- Undefined: abort goes directly to IDLE and storage retains stale keys, which are not readable because ready=0.

Decomposition:
- Package present_pkg holds:
  - KEY_SIZE and NUM_ROUNDS defaults, RK_W;
  - the state enum type;
  - the 4-bit S-box function;
  - the key-update function for the 80- and 128-bit variants.
- One natural sub-module: present_key_round. It is the combinational single-round update (key_reg, cnt -> nk) and is instantiated once.

Test Plan:
- key_in=0 (80-bit), start pulse:
  - busy=1 for 31 cycles, then ready=1;
  - rd_idx=0 -> 0000000000000000;
  - rd_idx=1 -> C000000000000000;
  - rd_idx=31 -> 6DAB31744F41D700.
- key_in=FFFF_FFFFFFFF_FFFFFFFF: all 32 round keys match the golden model; rd_valid follows rd_en by exactly 1 cycle.
- start at cycle 10 of expansion: ignored, ready still at E0+31. abort at cycle 10: IDLE next edge, ready=0, rd_en -> rd_valid=0.
- start and abort together in READY: IDLE, no restart.
- rst_n low mid-expansion: busy, ready, rd_valid and rd_key all 0 immediately.
- PRESENT_KEY_ZEROIZE_EN:
  - abort in READY -> busy=1 for 32 cycles, then IDLE;
  - a new start then expands correctly;
  - a backdoor peek shows storage all zero before the restart.
